// File: rtl/valid_pattern_gen.sv
// VALTRAIN word source for mainband valid-lane training: emits 32'hF0F0F0F0
// words (optionally error-masked) as a fixed-length burst or a free-running stream.
module valid_pattern_gen #(
  parameter int ITERATIONS = 128,
  parameter int CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_mode,
  input  logic             i_stop,
  input  logic             i_tx_ready,
  input  logic [31:0]      i_err_mask,
  output logic [31:0]      o_word,
  output logic             o_word_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_aborted,
  output logic             o_mode_err,
  output logic [CNT_W-1:0] o_words_sent
);

  localparam int          WORDS   = ITERATIONS / 4;
  localparam int          REM_W   = $clog2(WORDS + 1);
  localparam logic [31:0] PATTERN = 32'hF0F0_F0F0;
  localparam logic [1:0]  MODE_ITER   = 2'b01;
  localparam logic [1:0]  MODE_CONSEC = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_mode_iter, w_mode_iter_nxt;
  logic [REM_W-1:0]   r_remain, w_remain_nxt;
  logic               r_stop_pend, w_stop_pend_nxt;
  logic [31:0]        r_word, w_word_nxt;
  logic               r_word_valid, w_word_valid_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic               r_aborted, w_aborted_nxt;
  logic               r_mode_err, w_mode_err_nxt;
  logic [CNT_W-1:0]   r_words_sent, w_words_sent_nxt;

  logic w_accept, w_last, w_stop, w_legal;

  assign w_accept = r_word_valid && i_tx_ready;
  assign w_last   = r_mode_iter && (r_remain == REM_W'(1));
  // A stop seen while the serializer stalls is remembered until the word goes out.
  assign w_stop   = r_stop_pend || i_stop;
  assign w_legal  = (i_mode == MODE_ITER) || (i_mode == MODE_CONSEC);

  // NOTE: sequential state uses non-blocking assignments and resets asynchronously.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (i_start && w_legal) w_state_nxt = S_SEND;
      S_SEND: if (w_accept && (w_last || w_stop)) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Computes the next value of every registered output and counter.
  always_comb begin
    // NOTE: every signal gets a default first so no path infers a latch.
    w_mode_iter_nxt   = r_mode_iter;
    w_remain_nxt      = r_remain;
    w_stop_pend_nxt   = r_stop_pend;
    w_word_nxt        = r_word;
    w_word_valid_nxt  = 1'b0;
    w_busy_nxt        = 1'b0;
    w_done_nxt        = 1'b0;
    w_aborted_nxt     = 1'b0;
    w_mode_err_nxt    = 1'b0;
    w_words_sent_nxt  = r_words_sent;
    unique case (r_state)
      S_IDLE: begin
        w_word_nxt      = '0;
        w_stop_pend_nxt = 1'b0;
        if (i_start) begin
          if (w_legal) begin
            w_mode_iter_nxt  = (i_mode == MODE_ITER);
            w_remain_nxt     = REM_W'(WORDS);
            w_words_sent_nxt = '0;
            w_word_nxt       = PATTERN ^ i_err_mask;
            w_word_valid_nxt = 1'b1;
            w_busy_nxt       = 1'b1;
          end else begin
            w_mode_err_nxt = 1'b1;
          end
        end
      end
      S_SEND: begin
        w_word_valid_nxt = 1'b1;
        w_busy_nxt       = 1'b1;
        if (i_stop) w_stop_pend_nxt = 1'b1;
        if (w_accept) begin
          if (r_words_sent != '1) w_words_sent_nxt = r_words_sent + CNT_W'(1);
          if (r_mode_iter) w_remain_nxt = r_remain - REM_W'(1);
          if (w_last || w_stop) begin
            w_word_nxt       = '0;
            w_word_valid_nxt = 1'b0;
            w_busy_nxt       = 1'b0;
            w_done_nxt       = 1'b1;
            // Stop on the final burst word still counts as normal completion.
            w_aborted_nxt    = r_mode_iter && !w_last;
          end else begin
            w_word_nxt = PATTERN ^ i_err_mask;
          end
        end
      end
      S_DONE: begin
        w_word_nxt      = '0;
        w_stop_pend_nxt = 1'b0;
        w_remain_nxt    = '0;
      end
      default: w_word_nxt = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode_iter  <= 1'b0;
      r_remain     <= '0;
      r_stop_pend  <= 1'b0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_mode_err   <= 1'b0;
      r_words_sent <= '0;
    end else begin
      r_mode_iter  <= w_mode_iter_nxt;
      r_remain     <= w_remain_nxt;
      r_stop_pend  <= w_stop_pend_nxt;
      r_word       <= w_word_nxt;
      r_word_valid <= w_word_valid_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_aborted    <= w_aborted_nxt;
      r_mode_err   <= w_mode_err_nxt;
      r_words_sent <= w_words_sent_nxt;
    end
  end

  assign o_word       = r_word;
  assign o_word_valid = r_word_valid;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_aborted    = r_aborted;
  assign o_mode_err   = r_mode_err;
  assign o_words_sent = r_words_sent;

endmodule
